// File: rtl/q4_mem_stage.sv
// Q4 memory-access stage: issues one load/store per memory op on the data bus, formats load/store data,
// and stalls upstream until the access completes. Optional macro: MISALIGN_TRAP_EN (trap misaligned halfword/word).
package q4_mem_pkg;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [4:0]  reg_wr_port;
    ctrl_t       ctrl;
  } q3q4_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] alu_out;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_wr_port;
    ctrl_t       ctrl;
  } q4q5_t;
endpackage

module q4_mem_stage
  import q4_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  q3q4_t           i_q3q4,
  output q4q5_t           o_q4q5,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_misalign
);

  // state  | meaning
  // IDLE   | pass-through; a memory op latches its bus fields here
  // REQ    | request on the bus, fields held until grant
  // WAIT   | load granted, waiting for rvalid
  // DONE   | latched result presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_is_b;
  logic        r_is_h;
  logic        r_uns;
  logic [1:0]  r_off;
  logic        r_misalign;
  logic [31:0] r_insn;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  ctrl_t       r_ctrl;

  logic        w_memop;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic        w_is_b;
  logic        w_is_h;
  logic [6:0]  w_mask;
  logic [6:0]  w_be_shift;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_mis;
  logic [31:0] w_rshift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  // Undefined funct3 values fall through to the word form.
  always_comb begin
    w_memop = i_q3q4.ctrl.mem_read | i_q3q4.ctrl.mem_write;
    w_we    = i_q3q4.ctrl.mem_write;
    w_f3    = i_q3q4.insn[14:12];
    w_off   = i_q3q4.alu_out[1:0];
    w_is_b  = (w_f3 == 3'b000) | (!w_we & (w_f3 == 3'b100));
    w_is_h  = (w_f3 == 3'b001) | (!w_we & (w_f3 == 3'b101));
    w_mask  = w_is_b ? 7'b000_0001 : (w_is_h ? 7'b000_0011 : 7'b000_1111);
    w_be_shift = w_mask << w_off;
    w_be    = w_we ? w_be_shift[3:0] : 4'b1111;
    if (w_is_b)
      w_wdata = {4{i_q3q4.rs2_data[7:0]}};
    else if (w_is_h)
      w_wdata = w_off[0] ? ({16'b0, i_q3q4.rs2_data[15:0]} << {w_off, 3'b000})
                         : {2{i_q3q4.rs2_data[15:0]}};
    else
      w_wdata = i_q3q4.rs2_data << {w_off, 3'b000};
`ifdef MISALIGN_TRAP_EN
    w_mis = (w_is_h & w_off[0]) | (!w_is_b & !w_is_h & (w_off != 2'b00));
`else
    w_mis = 1'b0;
`endif
  end

  always_comb begin
    w_rshift = i_dmem_rdata >> {r_off, 3'b000};
    w_byte   = w_rshift[7:0];
    w_half   = r_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    if (r_is_b)
      w_fmt = {{24{!r_uns & w_byte[7]}}, w_byte};
    else if (r_is_h)
      w_fmt = {{16{!r_uns & w_half[15]}}, w_half};
    else
      w_fmt = i_dmem_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_is_b     <= 1'b0;
      r_is_h     <= 1'b0;
      r_uns      <= 1'b0;
      r_off      <= '0;
      r_misalign <= 1'b0;
      r_insn     <= '0;
      r_alu      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            r_insn  <= i_q3q4.insn;
            r_alu   <= i_q3q4.alu_out;
            r_rd    <= i_q3q4.reg_wr_port;
            r_ctrl  <= i_q3q4.ctrl;
            r_we    <= w_we;
            r_is_b  <= w_is_b;
            r_is_h  <= w_is_h;
            r_uns   <= w_f3[2];
            r_off   <= w_off;
            r_rdata <= '0;
            if (w_mis) begin
              r_misalign <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= {i_q3q4.alu_out[31:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_dmem_gnt) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_state <= S_DONE;
            end else if (i_dmem_rvalid) begin
              r_rdata <= w_fmt;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            r_rdata <= w_fmt;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_stall = ((r_state == S_IDLE) & w_memop) | (r_state == S_REQ) | (r_state == S_WAIT);
    if (r_state == S_IDLE) begin
      o_q4q5.insn        = i_q3q4.insn;
      o_q4q5.alu_out     = i_q3q4.alu_out;
      o_q4q5.mem_rdata   = '0;
      o_q4q5.reg_wr_port = i_q3q4.reg_wr_port;
      o_q4q5.ctrl        = i_q3q4.ctrl;
    end else begin
      o_q4q5.insn        = r_insn;
      o_q4q5.alu_out     = r_alu;
      o_q4q5.mem_rdata   = r_rdata;
      o_q4q5.reg_wr_port = r_rd;
      o_q4q5.ctrl        = r_ctrl;
    end
  end

  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we & r_req;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_be    = r_be;
  assign o_dmem_wdata = r_wdata;
  assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_q4_mem_stage.sv
// Directed bench for q4_mem_stage: scoreboarded loads/stores with a scripted bus responder.
// Exercises the MISALIGN_TRAP_EN variant when that macro is defined.
module tb_q4_mem_stage;
  import q4_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  q3q4_t       q3q4;
  q4q5_t       q4q5;
  logic        stall, req, we, gnt, rvalid, misalign;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  int n_vec = 0;
  int n_err = 0;
  q4q5_t exp_q[$];

  always #5 clk = ~clk;

  q4_mem_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_q3q4(q3q4), .o_q4q5(q4q5), .o_stall(stall),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr), .o_dmem_be(be),
    .o_dmem_wdata(wdata), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid),
    .i_dmem_rdata(rdata), .o_misalign(misalign)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic q3q4_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] rs2);
    q3q4_t w;
    w.insn = {17'h0, f3, 5'd7, (wr ? 7'h23 : (rd ? 7'h03 : 7'h33))};
    w.alu_out = a;
    w.rs2_data = rs2;
    w.reg_wr_port = 5'd7;
    w.ctrl.mem_read = rd;
    w.ctrl.mem_write = wr;
    w.ctrl.reg_write = !wr;
    w.ctrl.mem_to_reg = rd;
    return w;
  endfunction

  function automatic q4q5_t exp_out(input q3q4_t w, input logic [31:0] d);
    q4q5_t e;
    e.insn = w.insn;
    e.alu_out = w.alu_out;
    e.mem_rdata = d;
    e.reg_wr_port = w.reg_wr_port;
    e.ctrl = w.ctrl;
    return e;
  endfunction

  // One memory op: push expectation, play the bus with the given grant/rvalid delays, compare at DONE.
  task automatic access(input string tag, input q3q4_t w, input int gnt_wait, input int rv_wait,
                        input logic [31:0] bus_data, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    int stalls = 0;
    int reqs = 0;
    int post = -1;
    bit done = 0;
    int e_stalls;
    q4q5_t e;
    e_stalls = 2 + gnt_wait + (w.ctrl.mem_write ? 0 : rv_wait);
    exp_q.push_back(exp_out(w, e_rdata));
    @(negedge clk);
    q3q4 = w;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      #1;
      if (post >= 0) post++;
      if (req) begin
        reqs++;
        if (reqs == 1) begin
          chk({tag, "_addr"}, 128'(addr), 128'(e_addr));
          chk({tag, "_be"}, 128'(be), 128'(e_be));
          chk({tag, "_we"}, 128'(we), 128'(w.ctrl.mem_write));
          if (w.ctrl.mem_write) chk({tag, "_wdata"}, 128'(wdata), 128'(e_wdata));
        end
        if (reqs > gnt_wait) begin
          gnt = 1'b1;
          post = 0;
          if (!w.ctrl.mem_write && rv_wait == 0) begin rvalid = 1'b1; rdata = bus_data; end
        end
      end else if (!w.ctrl.mem_write && post > 0 && post == rv_wait) begin
        rvalid = 1'b1; rdata = bus_data;
      end
      #1;
      if (stall) stalls++;
      else if (c > 0) begin
        done = 1;
        chk({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({tag, "_q4q5"}, 128'(q4q5), 128'(e));
        end
        chk({tag, "_stalls"}, 128'(stalls), 128'(e_stalls));
        chk({tag, "_req_cycles"}, 128'(reqs), 128'(gnt_wait + 1));
        chk({tag, "_misalign"}, 128'(misalign), 128'(0));
        q3q4 = mk(0, 0, 3'b000, 32'h0, 32'h0);
        gnt = 1'b0; rvalid = 1'b0;
      end
    end
    chk({tag, "_completed"}, 128'(done), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    q3q4_t w;
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    q3q4 = mk(0, 0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 128'(req), 128'(0));
    chk("rst_we", 128'(we), 128'(0));
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_be", 128'(be), 128'(0));
    chk("rst_wdata", 128'(wdata), 128'(0));
    chk("rst_misalign", 128'(misalign), 128'(0));
    chk("rst_stall", 128'(stall), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b0; rdata = '0;

    // Non-memory op passes straight through.
    w = mk(0, 0, 3'b000, 32'h10, 32'h55);
    q3q4 = w;
    #1;
    chk("add_q4q5", 128'(q4q5), 128'(exp_out(w, 32'h0)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("add_stall", 128'(stall), 128'(0));
      chk("add_req", 128'(req), 128'(0));
    end

    access("lb", mk(1, 0, 3'b000, 32'h1003, 32'h0), 0, 0, 32'h80FF_FF00,
           32'h1000, 4'b1111, 32'h0, 32'hFFFF_FF80);
    access("sh", mk(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD), 3, 0, 32'h0,
           32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access("lhu", mk(1, 0, 3'b101, 32'h0, 32'h0), 0, 4, 32'h0000_8001,
           32'h0, 4'b1111, 32'h0, 32'h0000_8001);

    // Stray rvalid while idle must not land anywhere.
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("stray_rdata", 128'(q4q5.mem_rdata), 128'(0));
    chk("stray_req", 128'(req), 128'(0));
    chk("stray_stall", 128'(stall), 128'(0));
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    access("lh", mk(1, 0, 3'b001, 32'h0042, 32'h0), 1, 2, 32'h8765_0000,
           32'h0040, 4'b1111, 32'h0, 32'hFFFF_8765);
    access("sb", mk(0, 1, 3'b000, 32'h0041, 32'h0000_00AA), 0, 0, 32'h0,
           32'h0040, 4'b0010, 32'hAAAA_AAAA, 32'h0);
    access("sw", mk(0, 1, 3'b010, 32'h0050, 32'hCAFE_F00D), 1, 0, 32'h0,
           32'h0050, 4'b1111, 32'hCAFE_F00D, 32'h0);
    access("lbu", mk(1, 0, 3'b100, 32'h0062, 32'h0), 2, 1, 32'h00F1_0000,
           32'h0060, 4'b1111, 32'h0, 32'h0000_00F1);
    access("ld_f3_110", mk(1, 0, 3'b110, 32'h0070, 32'h0), 0, 0, 32'h1234_5678,
           32'h0070, 4'b1111, 32'h0, 32'h1234_5678);

    // Reset while waiting for load data, then a late rvalid.
    @(negedge clk);
    q3q4 = mk(1, 0, 3'b010, 32'h0080, 32'h0);
    @(negedge clk); #1;
    chk("rstw_req", 128'(req), 128'(1));
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #1;
    chk("rstw_wait_stall", 128'(stall), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q3q4 = mk(0, 0, 3'b000, 32'h0, 32'h0);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    #1;
    chk("rstw_req_after", 128'(req), 128'(0));
    chk("rstw_stall_after", 128'(stall), 128'(0));
    chk("rstw_rdata_after", 128'(q4q5.mem_rdata), 128'(0));
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("rstw_idle_req", 128'(req), 128'(0));
    chk("rstw_idle_stall", 128'(stall), 128'(0));
    access("lw_after_rst", mk(1, 0, 3'b010, 32'h0084, 32'h0), 0, 1, 32'h0BAD_F00D,
           32'h0084, 4'b1111, 32'h0, 32'h0BAD_F00D);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    w = mk(1, 0, 3'b010, 32'h3, 32'h0);
    q3q4 = w;
    #1;
    chk("mis_stall", 128'(stall), 128'(1));
    chk("mis_req0", 128'(req), 128'(0));
    @(negedge clk); #1;
    chk("mis_done_stall", 128'(stall), 128'(0));
    chk("mis_pulse", 128'(misalign), 128'(1));
    chk("mis_done_req", 128'(req), 128'(0));
    chk("mis_q4q5", 128'(q4q5), 128'(exp_out(w, 32'h0)));
    q3q4 = mk(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("mis_pulse_end", 128'(misalign), 128'(0));
`else
    access("lw_mis", mk(1, 0, 3'b010, 32'h3, 32'h0), 0, 0, 32'h0102_0304,
           32'h0, 4'b1111, 32'h0, 32'h0102_0304);
    access("sh_a3", mk(0, 1, 3'b001, 32'h0093, 32'h1234_ABCD), 0, 0, 32'h0,
           32'h0090, 4'b1000, 32'hCD00_0000, 32'h0);
`endif

    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
